// File: rtl/shim_pkg.sv
// Shared types and defaults for the multi-channel 4-phase receive shim.
package shim_pkg;
  typedef enum logic {IDLE = 1'b0, ACKED = 1'b1} shim_state_t;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_WIDTH       = 12;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_SYNC_STAGES = 2;

  // Channel-id width; a single channel still needs one bit.
  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/shim_rx_chan.sv
// One 4-phase receive channel: req synchroniser, IDLE/ACKED handshake FSM and token FIFO.
module shim_rx_chan
  import shim_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_ack,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int AW = $clog2(DEPTH);

  logic [SYNC_STAGES-1:0] r_sync;
  shim_state_t            r_state;
  logic                   r_ack;
  logic [AW:0]            r_wptr, r_rptr;
  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic                   w_req_s, w_full, w_push;

  assign w_req_s = r_sync[SYNC_STAGES-1];
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty = (r_wptr == r_rptr);
  // A full FIFO stalls the handshake: ack stays low and the sender keeps req high.
  assign w_push  = (r_state == IDLE) && w_req_s && !w_full;
  assign o_ack   = r_ack;
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_req};
      if (w_push) begin
        r_wptr  <= r_wptr + (AW+1)'(1);
        r_ack   <= 1'b1;
        r_state <= ACKED;
      end else if (r_state == ACKED && !w_req_s) begin
        r_ack   <= 1'b0;
        r_state <= IDLE;
      end
      if (i_pop) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/shim_rx_mux.sv
// NUM_CH asynchronous 4-phase senders merged onto one registered, channel-tagged valid/ready port.
module shim_rx_mux
  import shim_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           in_req,
  output logic [NUM_CH-1:0]           in_ack,
  input  logic [NUM_CH*WIDTH-1:0]     in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [chw(NUM_CH)-1:0]      out_chan
);
  localparam int CHW = chw(NUM_CH);

  logic [NUM_CH-1:0]            w_empty, w_pop;
  logic [NUM_CH-1:0][WIDTH-1:0] w_head;
  logic [CHW-1:0]               w_win, w_idx, r_rr, r_chan;
  logic                         w_found, w_free, r_valid;
  logic [WIDTH-1:0]             r_data;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    shim_rx_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)) u_chan (
      .clk    (clk),
      .rst_n  (reset),
      .i_req  (in_req[c]),
      .i_data (in_data[c*WIDTH +: WIDTH]),
      .i_pop  (w_pop[c]),
      .o_ack  (in_ack[c]),
      .o_empty(w_empty[c]),
      .o_head (w_head[c])
    );
  end

  // Round-robin search starting at r_rr, wrapping modulo NUM_CH.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = CHW'((int'(r_rr) + i) % NUM_CH);
      if (!w_found && !w_empty[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_free = !r_valid || out_ready;

  always_comb begin
    w_pop = '0;
    if (w_free && w_found) w_pop[w_win] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_rr    <= '0;
    end else if (w_free) begin
      r_valid <= w_found;
      if (w_found) begin
        r_data <= w_head[w_win];
        r_chan <= w_win;
        r_rr   <= (w_win == CHW'(NUM_CH-1)) ? '0 : w_win + CHW'(1);
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_chan  = r_chan;
endmodule

// File: tb/tb_shim_rx_mux.sv
// Directed bench for shim_rx_mux: latency, backpressure/full, round-robin, hold, async reset, stream.
module tb_shim_rx_mux;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 12;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_CH-1:0]       in_req, in_ack;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic                    out_valid, out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [1:0]              out_chan;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shim_rx_mux #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input int ch, input logic lvl, input int bound, output bit ok);
    ok = (in_ack[ch] == lvl);
    for (int i = 0; i < bound && !ok; i++) begin
      step();
      ok = (in_ack[ch] == lvl);
    end
  endtask

  // Full 4-phase handshake on one channel; ok=0 if either edge of ack times out.
  task automatic send(input int ch, input logic [WIDTH-1:0] v, output bit ok);
    bit ok2;
    in_data[ch*WIDTH +: WIDTH] = v;
    in_req[ch] = 1'b1;
    wait_ack(ch, 1'b1, 10, ok);
    in_req[ch] = 1'b0;
    wait_ack(ch, 1'b0, 10, ok2);
    ok = ok && ok2;
  endtask

  task automatic expect_out(input string tag, input int d, input int ch);
    int n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_data"}, 32'(out_data), d);
    chk({tag, "_chan"}, 32'(out_chan), ch);
    step();
  endtask

  logic [WIDTH-1:0] stream [7] = '{12'd14, 12'd5, 12'd118, 12'd51, 12'd27, 12'd8, 12'd77};
  logic [WIDTH-1:0] got_d [$];
  logic [1:0]       got_c [$];

  initial begin
    bit ok, ok_a, ok_b;
    logic [WIDTH-1:0] hd;
    logic [1:0]       hc;
    int               send_fail;

    reset = 1'b0; in_req = '0; in_data = '0; out_ready = 1'b0;
    #12;
    chk("rst_ack", 32'(in_ack), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_chan", 32'(out_chan), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    step();

    // 1: single token latency on ch0
    out_ready = 1'b1;
    in_data[0 +: WIDTH] = 12'd14;
    in_req[0] = 1'b1;
    step(); step();
    chk("t1_ack_e2", 32'(in_ack[0]), 0);
    step();
    chk("t1_ack_e3", 32'(in_ack[0]), 1);
    chk("t1_valid_e3", 32'(out_valid), 0);
    step();
    chk("t1_valid_e4", 32'(out_valid), 1);
    chk("t1_data", 32'(out_data), 14);
    chk("t1_chan", 32'(out_chan), 0);
    in_req[0] = 1'b0;
    step(); step();
    chk("t1_ackfall_e2", 32'(in_ack[0]), 1);
    step();
    chk("t1_ackfall_e3", 32'(in_ack[0]), 0);
    repeat (3) step();

    // 2: backpressure, five tokens fit, sixth stalls
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send(1, 12'(100 + k), ok);
      chk($sformatf("t2_ack%0d", k), 32'(ok), 1);
    end
    in_data[1*WIDTH +: WIDTH] = 12'd105;
    in_req[1] = 1'b1;
    repeat (20) step();
    chk("t2_ack6_stall", 32'(in_ack[1]), 0);
    chk("t2_head", 32'(out_data), 100);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    wait_ack(1, 1'b1, 3, ok);
    chk("t2_ack6_after_pulse", 32'(ok), 1);
    in_req[1] = 1'b0;
    wait_ack(1, 1'b0, 10, ok);
    chk("t2_ack6_fall", 32'(ok), 1);
    out_ready = 1'b1;
    for (int k = 1; k < 6; k++) expect_out($sformatf("t2_out%0d", k), 100 + k, 1);
    repeat (3) step();

    // 3: round-robin order
    out_ready = 1'b0;
    send(0, 12'd5, ok);   chk("t3_s0", 32'(ok), 1);
    send(1, 12'd118, ok); chk("t3_s1", 32'(ok), 1);
    send(2, 12'd51, ok);  chk("t3_s2", 32'(ok), 1);
    send(3, 12'd27, ok);  chk("t3_s3", 32'(ok), 1);
    out_ready = 1'b1;
    expect_out("t3_o0", 5, 0);
    expect_out("t3_o1", 118, 1);
    expect_out("t3_o2", 51, 2);
    expect_out("t3_o3", 27, 3);
    repeat (2) step();
    out_ready = 1'b0;
    in_data[2*WIDTH +: WIDTH] = 12'd33;
    in_data[0 +: WIDTH] = 12'd9;
    in_req[2] = 1'b1; in_req[0] = 1'b1;
    wait_ack(0, 1'b1, 10, ok_a);
    wait_ack(2, 1'b1, 10, ok_b);
    chk("t3_dual_ack", 32'(ok_a && ok_b), 1);
    in_req[2] = 1'b0; in_req[0] = 1'b0;
    wait_ack(0, 1'b0, 10, ok_a);
    wait_ack(2, 1'b0, 10, ok_b);
    out_ready = 1'b1;
    expect_out("t3_r0", 9, 0);
    expect_out("t3_r2", 33, 2);
    repeat (2) step();

    // 4: hold while out_ready=0
    out_ready = 1'b0;
    send(3, 12'd999, ok);
    chk("t4_send", 32'(ok), 1);
    hd = out_data; hc = out_chan;
    chk("t4_data0", 32'(hd), 999);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t4_valid%0d", k), 32'(out_valid), 1);
      chk($sformatf("t4_hold%0d", k), {18'd0, out_chan, out_data}, {18'd0, 2'd3, 12'd999});
      step();
    end
    out_ready = 1'b1;
    step();
    chk("t4_accepted", 32'(out_valid), 0);

    // 5: asynchronous reset mid-operation
    out_ready = 1'b0;
    send(1, 12'd7, ok);
    send(2, 12'd8, ok);
    in_data[0 +: WIDTH] = 12'd9;
    in_req[0] = 1'b1;
    wait_ack(0, 1'b1, 10, ok);
    chk("t5_ack_pre", 32'(ok), 1);
    chk("t5_valid_pre", 32'(out_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_ack_async", 32'(in_ack), 0);
    chk("t5_valid_async", 32'(out_valid), 0);
    in_req[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) ok = 1'b0;
      step();
    end
    chk("t5_no_stale", 32'(ok), 1);

    // 6: stream on ch0 with random out_ready
    send_fail = 0;
    fork
      begin
        bit s_ok;
        for (int k = 0; k < 7; k++) begin
          send(0, stream[k], s_ok);
          if (!s_ok) send_fail++;
        end
      end
      begin
        for (int k = 0; k < 3000 && got_d.size() < 7; k++) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_c.push_back(out_chan);
          end
        end
      end
    join
    out_ready = 1'b1;
    repeat (5) step();
    chk("t6_send_ok", 32'(send_fail), 0);
    chk("t6_count", 32'(got_d.size()), 7);
    chk("t6_no_extra", 32'(out_valid), 0);
    for (int k = 0; k < 7; k++) begin
      if (k < got_d.size()) begin
        chk($sformatf("t6_data%0d", k), 32'(got_d[k]), 32'(stream[k]));
        chk($sformatf("t6_chan%0d", k), 32'(got_c[k]), 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
